uart_tx_param: RTL and testbench

//  Parametrised UART transmitter. Next generation of the fixed 8N1 free-running TX.

---
 rtl/uart_tx_param.sv | 183 ++++++++++++++++++
 tb/tb_uart_tx_param.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// uart_tx_param -- parametrised UART transmitter with a valid/ready byte handshake.
//
// Sits between a word source (FIFO/CPU) and the serial TX pin. One word is accepted
// per frame. The frame is a start bit, DATA_BITS data bits (LSB first), an optional
// parity bit, then STOP_BITS stop bits. Each bit is held for CLKS_PER_BIT cycles.
//
// Handshake: a word transfers on any rising edge where tx_valid && tx_ready.
// tx_ready is high only while the FSM is IDLE. The source may change tx_data or
// drop tx_valid at any time without effect while the block is busy.
//
// Ports:
//   tx_clk     in   1          system clock, rising edge
//   RST        in   1          synchronous reset, active-high
//   tx_data    in   DATA_BITS  word to send, sampled only on the accept edge
//   tx_valid   in   1          source has a word on tx_data
//   tx_ready   out  1          block can accept a word (IDLE)
//   tx_output  out  1          serial line, idle high (registered)
//   tx_busy    out  1          frame in progress
//   tx_done    out  1          one-cycle pulse on the edge that ends the last stop bit
//   dbg_state  out  3          current FSM state encoding, for observation only
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 tx_clk,
  input  logic                 RST,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx_output,
  output logic                 tx_busy,
  output logic                 tx_done,
  output logic [2:0]           dbg_state
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_param: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CYC_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam logic          PAR_ODD   = (PARITY == 1);
  localparam logic          HAS_PAR   = (PARITY != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   par_q,   par_d;
  logic [3:0]             bit_q,   bit_d;
  logic [CW-1:0]          cyc_q,   cyc_d;
  logic                   out_q,   out_d;
  logic                   done_q,  done_d;
  logic                   bit_end;

  // Last cycle of the current serial bit.
  assign bit_end = (cyc_q == CYC_LAST);

  always_ff @(posedge tx_clk) begin
    if (RST) begin
      state_q <= S_IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      cyc_q   <= '0;
      out_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      cyc_q   <= cyc_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  // The line level is computed one edge ahead so tx_output is a clean register
  // that changes on exactly the same edge as the state.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    cyc_d   = cyc_q;
    out_d   = out_q;
    done_d  = 1'b0;

    if (state_q != S_IDLE) begin
      cyc_d = bit_end ? '0 : cyc_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        out_d = 1'b1;
        if (tx_valid) begin
          state_d = S_START;
          shift_d = tx_data;
          par_d   = (^tx_data) ^ PAR_ODD;
          bit_d   = '0;
          cyc_d   = '0;
          out_d   = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          out_d   = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == DATA_LAST) begin
            bit_d = '0;
            if (HAS_PAR) begin
              state_d = S_PARITY;
              out_d   = par_q;
            end else begin
              state_d = S_STOP;
              out_d   = 1'b1;
            end
          end else begin
            // Shift right so the next data bit is always at position 0.
            bit_d   = bit_q + 4'd1;
            shift_d = {1'b0, shift_q[DATA_BITS-1:1]};
            out_d   = shift_d[0];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          bit_d   = '0;
          out_d   = 1'b1;
        end
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
            done_d  = 1'b1;
          end else begin
            bit_d = bit_q + 4'd1;
          end
          out_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        out_d   = 1'b1;
      end
    endcase
  end

  assign tx_busy   = (state_q != S_IDLE);
  assign tx_ready  = ~tx_busy;
  assign tx_output = out_q;
  assign tx_done   = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param. Five instances cover 8N1, 8E2, 8O1, 7N1 (all 4 clocks
// per bit) and 8N1 at 434 clocks per bit. A selector routes one instance at a time
// to the shared stimulus and to the line monitor. Expected frames are hand-computed
// bit strings: bit 0 is the start bit, then data LSB first, parity, stop bits.
module tb_uart_tx_param;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic RST = 1'b1;

  // ---------------- stimulus signals ----------------
  logic [2:0] sel    = 3'd0;
  logic [7:0] tdata  = 8'h00;
  logic       tvalid = 1'b0;

  logic [4:0] line_v, ready_v, busy_v, done_v;
  logic [2:0] st0, st1, st2, st3, st4;

  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .tx_clk(clk), .RST(RST), .tx_data(tdata), .tx_valid(tvalid & (sel == 3'd0)),
    .tx_ready(ready_v[0]), .tx_output(line_v[0]), .tx_busy(busy_v[0]),
    .tx_done(done_v[0]), .dbg_state(st0));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) u_8e2 (
    .tx_clk(clk), .RST(RST), .tx_data(tdata), .tx_valid(tvalid & (sel == 3'd1)),
    .tx_ready(ready_v[1]), .tx_output(line_v[1]), .tx_busy(busy_v[1]),
    .tx_done(done_v[1]), .dbg_state(st1));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .tx_clk(clk), .RST(RST), .tx_data(tdata), .tx_valid(tvalid & (sel == 3'd2)),
    .tx_ready(ready_v[2]), .tx_output(line_v[2]), .tx_busy(busy_v[2]),
    .tx_done(done_v[2]), .dbg_state(st2));
  uart_tx_param #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(1)) u_7n1 (
    .tx_clk(clk), .RST(RST), .tx_data(tdata[6:0]), .tx_valid(tvalid & (sel == 3'd3)),
    .tx_ready(ready_v[3]), .tx_output(line_v[3]), .tx_busy(busy_v[3]),
    .tx_done(done_v[3]), .dbg_state(st3));
  uart_tx_param #(.CLKS_PER_BIT(434), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_slow (
    .tx_clk(clk), .RST(RST), .tx_data(tdata), .tx_valid(tvalid & (sel == 3'd4)),
    .tx_ready(ready_v[4]), .tx_output(line_v[4]), .tx_busy(busy_v[4]),
    .tx_done(done_v[4]), .dbg_state(st4));

  logic m_line, m_ready, m_busy, m_done;
  logic [2:0] m_state;
  assign m_line  = line_v[sel];
  assign m_ready = ready_v[sel];
  assign m_busy  = busy_v[sel];
  assign m_done  = done_v[sel];
  always_comb begin
    case (sel)
      3'd0:    m_state = st0;
      3'd1:    m_state = st1;
      3'd2:    m_state = st2;
      3'd3:    m_state = st3;
      default: m_state = st4;
    endcase
  end

  // ---------------- scoreboard ----------------
  // Entry: {frame length in bits [19:16], frame bits [15:0]}.
  logic [19:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  // Samples on the falling edge. A low line while idle is a start bit; each bit is
  // sampled for cpb cycles and must hold its level; tx_done must appear exactly on
  // the sample after the last stop bit, together with ready and a high line.
  initial begin : monitor
    logic [19:0] ent;
    logic [15:0] got;
    int nb, cpb;
    logic held, early, aborted;
    forever begin
      @(negedge clk);
      if (RST !== 1'b0) continue;
      if (m_done === 1'b1) check("spurious done", 32'(m_done), 32'd0);
      if (m_line === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected frame", 32'(exp_q.size()), 32'd1);
          for (int k = 0; k < 5000 && m_line === 1'b0; k++) @(negedge clk);
          continue;
        end
        ent = exp_q[0];
        nb  = int'(ent[19:16]);
        cpb = (sel == 3'd4) ? 434 : 4;
        got = '0;
        held = 1'b1;
        early = 1'b0;
        aborted = 1'b0;
        for (int b = 0; b < nb && !aborted; b++) begin
          for (int c = 0; c < cpb && !aborted; c++) begin
            if (!(b == 0 && c == 0)) @(negedge clk);
            if (RST === 1'b1) begin
              aborted = 1'b1;
            end else begin
              if (c == 0) got[b] = m_line;
              else if (m_line !== got[b]) held = 1'b0;
              if (m_done === 1'b1) early = 1'b1;
            end
          end
        end
        if (!aborted) begin
          @(negedge clk);
          if (RST === 1'b1) aborted = 1'b1;
        end
        if (aborted) begin
          void'(exp_q.pop_front());
          continue;
        end
        check("frame bits", 32'(got), 32'(ent[15:0]));
        check("bit hold", 32'(held), 32'd1);
        check("early done", 32'(early), 32'd0);
        check("done/ready/line at frame end", {29'd0, m_done, m_ready, m_line}, 32'd7);
        void'(exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present a word until accepted; returns at accept edge + 1.
  task automatic offer(input logic [7:0] d);
    logic acc;
    int n;
    tdata  = d;
    tvalid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      acc = m_ready;
      @(posedge clk); #1;
      n++;
    end
    check("accept", 32'(acc), 32'd1);
  endtask

  // Count edges until tx_done is seen, bounded.
  task automatic wait_done(input int lat, input string name);
    int cnt;
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (m_done !== 1'b1 && cnt < lat + 50);
    check(name, cnt, lat);
  endtask

  task automatic send(input logic [7:0] d, input logic [19:0] ent, input int lat,
                      input string name);
    exp_q.push_back(ent);
    offer(d);
    tvalid = 1'b0;
    wait_done(lat, name);
  endtask

  task automatic check_idle(input string name);
    check(name, {27'd0, m_line, m_ready, m_busy, m_done, 1'b0}, {27'd0, 5'b11000});
    check({name, " state"}, 32'(m_state), 32'd0);
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // ---------------- watchdog ----------------
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin : main
    RST = 1'b1;
    idle_cycles(3);
    RST = 1'b0;
    check_idle("reset idle");

    // 8N1 0x55: 0 | 1,0,1,0,1,0,1,0 | 1
    send(8'h55, {4'd10, 16'h02AA}, 40, "8N1 0x55 latency");
    idle_cycles(2);

    // 8E2 0x07: three ones -> even parity bit 1, stops 1,1
    sel = 3'd1; idle_cycles(1);
    send(8'h07, {4'd12, 16'h0E0E}, 48, "8E2 0x07 latency");
    idle_cycles(2);

    // 8O1 0x07: odd parity bit 0
    sel = 3'd2; idle_cycles(1);
    send(8'h07, {4'd11, 16'h040E}, 44, "8O1 0x07 latency");
    idle_cycles(2);

    // 7N1: port bit 7 driven high but not part of the 7-bit word
    sel = 3'd3; idle_cycles(1);
    send(8'hFF, {4'd9, 16'h01FE}, 36, "7N1 0x7F latency");
    idle_cycles(2);

    // Back-to-back 0xA5 then 0x3C with valid held high; data scribbled mid-frame.
    sel = 3'd0; idle_cycles(1);
    exp_q.push_back({4'd10, 16'h034A});
    exp_q.push_back({4'd10, 16'h0278});
    offer(8'hA5);
    tdata = 8'hFF;
    idle_cycles(10);
    tdata = 8'h3C;
    wait_done(30, "b2b frame1 latency");
    check("b2b ready with done", 32'(m_ready), 32'd1);
    @(posedge clk); #1;
    check("b2b second start", {30'd0, m_line, m_busy}, 32'd1);
    tvalid = 1'b0;
    wait_done(40, "b2b frame2 latency");
    idle_cycles(2);

    // Abort: reset 10 cycles into a frame, held 3 cycles.
    exp_q.push_back({4'd10, 16'h02AA});
    offer(8'h55);
    tvalid = 1'b0;
    idle_cycles(10);
    check("abort line low before reset", 32'(m_line), 32'd0);
    RST = 1'b1;
    @(posedge clk); #1;
    check("abort line high after reset edge", {30'd0, m_line, m_done}, 32'd2);
    idle_cycles(2);
    RST = 1'b0;
    check_idle("after abort reset");
    idle_cycles(60);
    check("abort no done", 32'(m_done), 32'd0);
    send(8'hC3, {4'd10, 16'h0386}, 40, "post-abort 0xC3 latency");
    idle_cycles(2);

    // 434 clocks per bit: 10 bits -> 4340 cycles.
    sel = 3'd4; idle_cycles(1);
    send(8'h0F, {4'd10, 16'h021E}, 4340, "434cpb 0x0F latency");
    idle_cycles(3);

    check("queue drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
